// File: rtl/multi_timer_pkg.sv
// multi_timer shared types and helpers.
// Channel state encoding and the select-width function.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } ch_state_t;

  localparam int PS_W = 8;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/multi_timer_if.sv
// multi_timer register/control bundle.
// master drives controls, slave returns status.
interface multi_timer_if
  import multi_timer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
);

  localparam int SW = clogb2(NCH);

  logic             CE;
  logic             WR;
  logic [SW-1:0]    CH_SEL;
  logic [WIDTH-1:0] TERM;
  logic             PERIODIC;
  logic [NCH-1:0]   START;
  logic [NCH-1:0]   STOP;
  logic [NCH-1:0]   IRQ_ACK;
  logic [NCH-1:0]   RUNNING;
  logic [NCH-1:0]   DONE;
  logic [NCH-1:0]   PENDING;
  logic             IRQ;

  modport master (
    output CE, WR, CH_SEL, TERM,
    output PERIODIC, START, STOP,
    output IRQ_ACK,
    input  RUNNING, DONE, PENDING,
    input  IRQ
  );

  modport slave (
    input  CE, WR, CH_SEL, TERM,
    input  PERIODIC, START, STOP,
    input  IRQ_ACK,
    output RUNNING, DONE, PENDING,
    output IRQ
  );

endinterface

// File: rtl/multi_timer_channel.sv
// One timer channel: term, mode, count,
// IDLE/RUN/EXPIRED state and sticky pending.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_term,
  input  logic             wr_per,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  output logic             running,
  output logic             done,
  output logic             pending
);

  ch_state_t        state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] term_q;
  logic             per_q;
  logic             done_q;
  logic             pend_q;

  logic [WIDTH-1:0] term_n;
  logic             per_n;
  logic [WIDTH:0]   lim;
  logic [WIDTH:0]   cnt_inc;
  logic             hit;
  logic             start_exp;
  logic             run_exp;
  logic             expire;

  // Writes apply in the same cycle; periodic term 0 acts as 1.
  always_comb begin
    term_n    = wr ? wr_term : term_q;
    per_n     = wr ? wr_per : per_q;
    lim       = {1'b0, term_n};
    if (per_n && (term_n == '0))
      lim = (WIDTH+1)'(1);
    cnt_inc   = {1'b0, count_q} + 1'b1;
    hit       = (cnt_inc >= lim);
    start_exp = !per_n && (term_n == '0);
    run_exp   = (state_q == ST_RUN) && tick && hit;
    expire    = !stop && (start ? start_exp : run_exp);
  end

  // Channel state machine; stop beats start beats counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      term_q  <= '0;
      per_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      term_q <= term_n;
      per_q  <= per_n;
      pend_q <= expire | (pend_q & ~ack);
      if (stop) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        done_q  <= 1'b0;
      end else if (start) begin
        count_q <= '0;
        if (start_exp) begin
          state_q <= ST_EXPIRED;
          done_q  <= 1'b1;
        end else begin
          state_q <= ST_RUN;
          done_q  <= 1'b0;
        end
      end else if (state_q == ST_RUN && tick) begin
        if (hit) begin
          done_q <= 1'b1;
          if (per_n) begin
            count_q <= '0;
          end else begin
            state_q <= ST_EXPIRED;
            count_q <= term_n;
          end
        end else begin
          count_q <= cnt_inc[WIDTH-1:0];
          done_q  <= 1'b0;
        end
      end else begin
        done_q <= (state_q == ST_EXPIRED);
      end
    end
  end

  assign running = (state_q == ST_RUN);
  assign done    = done_q;
  assign pending = pend_q;

endmodule

// File: rtl/multi_timer.sv
// multi_timer top: NCH channels, tick source, IRQ.
// Optional CE prescaler: define MULTI_TIMER_PRESCALE_EN.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input logic          CLK,
  input logic          RST,
  multi_timer_if.slave bus
);

  localparam int SW = clogb2(NCH);

  if (NCH < 2 || NCH > 16 ||
      PRESCALE < 1 || PRESCALE > 256) begin : g_bad_cfg
    $error("multi_timer: parameter out of range");
  end

  logic           tick;
  logic [NCH-1:0] pend;
  logic           irq_q;

`ifdef MULTI_TIMER_PRESCALE_EN
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] pre_q;

  assign tick = bus.CE && (pre_q == PS_LAST);

  // Count CE cycles, wrapping after the last one.
  always_ff @(posedge CLK) begin
    if (RST)
      pre_q <= '0;
    else if (bus.CE)
      pre_q <= (pre_q == PS_LAST) ? '0 : pre_q + 1'b1;
  end
`else
  assign tick = bus.CE;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr_i;

    assign wr_i = bus.WR && (bus.CH_SEL == SW'(i));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (CLK),
      .rst     (RST),
      .tick    (tick),
      .wr      (wr_i),
      .wr_term (bus.TERM),
      .wr_per  (bus.PERIODIC),
      .start   (bus.START[i]),
      .stop    (bus.STOP[i]),
      .ack     (bus.IRQ_ACK[i]),
      .running (bus.RUNNING[i]),
      .done    (bus.DONE[i]),
      .pending (pend[i])
    );
  end

  // Interrupt follows any pending flag by one cycle.
  always_ff @(posedge CLK) begin
    if (RST)
      irq_q <= 1'b0;
    else
      irq_q <= |pend;
  end

  assign bus.PENDING = pend;
  assign bus.IRQ     = irq_q;

endmodule

// File: tb/tb_multi_timer.sv
// multi_timer bench: directed scenarios plus
// random traffic against a cycle reference model.
module tb_multi_timer;
  import multi_timer_pkg::*;

  localparam int NCH      = 4;
  localparam int WIDTH    = 16;
  localparam int PRESCALE = 4;
  localparam int SW       = clogb2(NCH);
`ifdef MULTI_TIMER_PRESCALE_EN
  localparam int TP = PRESCALE;
`else
  localparam int TP = 1;
`endif

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  multi_timer_if #(.NCH(NCH), .WIDTH(WIDTH)) bus();

  multi_timer #(
    .NCH(NCH), .WIDTH(WIDTH), .PRESCALE(PRESCALE)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 counting, 2 finished
  int             m_mode [NCH];
  int             m_cnt  [NCH];
  int             m_term [NCH];
  bit [NCH-1:0]   m_per;
  bit [NCH-1:0]   m_pend;
  bit [NCH-1:0]   m_done;
  bit             m_irq;
  int             m_pre;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0;
      m_cnt[i]  = 0;
      m_term[i] = 0;
    end
    m_per  = '0;
    m_pend = '0;
    m_done = '0;
    m_irq  = 1'b0;
    m_pre  = 0;
  endtask

  task automatic step(input bit rst, input bit ce,
                      input bit wr, input int sel,
                      input int term, input bit per,
                      input bit [NCH-1:0] start,
                      input bit [NCH-1:0] stop,
                      input bit [NCH-1:0] ack);
    bit tick;
    bit any_p;
    bit fired;
    int lim;
    bit [NCH-1:0] exp_run;
    RST          = rst;
    bus.CE       = ce;
    bus.WR       = wr;
    bus.CH_SEL   = SW'(sel);
    bus.TERM     = WIDTH'(term);
    bus.PERIODIC = per;
    bus.START    = start;
    bus.STOP     = stop;
    bus.IRQ_ACK  = ack;
    @(posedge CLK);
    if (rst) begin
      model_reset();
    end else begin
      any_p = |m_pend;
`ifdef MULTI_TIMER_PRESCALE_EN
      tick = ce && (m_pre == PRESCALE - 1);
      if (ce) m_pre = (m_pre + 1) % PRESCALE;
`else
      tick = ce;
`endif
      for (int i = 0; i < NCH; i++) begin
        fired = 1'b0;
        if (wr && sel == i) begin
          m_term[i] = term;
          m_per[i]  = per;
        end
        lim = m_term[i];
        if (m_per[i] && lim == 0) lim = 1;
        if (stop[i]) begin
          m_mode[i] = 0;
          m_cnt[i]  = 0;
        end else if (start[i]) begin
          m_cnt[i] = 0;
          if (!m_per[i] && m_term[i] == 0) begin
            m_mode[i] = 2;
            fired     = 1'b1;
          end else begin
            m_mode[i] = 1;
          end
        end else if (m_mode[i] == 1 && tick) begin
          if (m_cnt[i] + 1 >= lim) begin
            fired = 1'b1;
            if (m_per[i]) begin
              m_cnt[i] = 0;
            end else begin
              m_mode[i] = 2;
              m_cnt[i]  = m_term[i];
            end
          end else begin
            m_cnt[i]++;
          end
        end
        m_pend[i] = fired | (m_pend[i] & ~ack[i]);
        m_done[i] = (m_mode[i] == 2) | (fired & m_per[i]);
      end
      m_irq = any_p;
    end
    #1;
    for (int i = 0; i < NCH; i++)
      exp_run[i] = (m_mode[i] == 1);
    chk("running", 32'(bus.RUNNING), 32'(exp_run));
    chk("done", 32'(bus.DONE), 32'(m_done));
    chk("pending", 32'(bus.PENDING), 32'(m_pend));
    chk("irq", 32'(bus.IRQ), 32'(m_irq));
  endtask

  task automatic idle(input bit ce);
    step(0, ce, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    int pulses;
    int first;
    int last;
    bit gap_ok;
    int n;

    // Reset state
    do_reset();
    chk("rst_running", 32'(bus.RUNNING), 32'h0);
    chk("rst_done", 32'(bus.DONE), 32'h0);
    chk("rst_pending", 32'(bus.PENDING), 32'h0);
    chk("rst_irq", 32'(bus.IRQ), 32'h0);

    // One-shot term 5 on channel 0
    step(0, 0, 1, 0, 5, 0, 4'b0001, '0, '0);
    chk("os_started", 32'(bus.RUNNING[0]), 32'h1);
    repeat (5 * TP - 1) idle(1);
    chk("os_early", 32'(bus.DONE[0]), 32'h0);
    idle(1);
    chk("os_done", 32'(bus.DONE[0]), 32'h1);
    chk("os_pend", 32'(bus.PENDING[0]), 32'h1);
    chk("os_stopped", 32'(bus.RUNNING[0]), 32'h0);
    idle(1);
    chk("os_irq", 32'(bus.IRQ), 32'h1);
    chk("os_held", 32'(bus.DONE[0]), 32'h1);

    // Periodic term 3 on channel 1
    do_reset();
    step(0, 0, 1, 1, 3, 1, 4'b0010, '0, '0);
    pulses = 0;
    first  = -1;
    last   = -1;
    gap_ok = 1'b1;
    for (int c = 1; c <= 9 * TP; c++) begin
      idle(1);
      if (bus.DONE[1]) begin
        if (pulses == 0) first = c;
        else if (c - last != 3 * TP) gap_ok = 1'b0;
        last = c;
        pulses++;
      end
    end
    chk("per_pulses", 32'(pulses), 32'd3);
    chk("per_first", 32'(first), 32'(3 * TP));
    chk("per_gap", 32'(gap_ok), 32'h1);

    // One-shot term 0 expires without a tick
    do_reset();
    step(0, 0, 1, 2, 0, 0, 4'b0100, '0, '0);
    chk("t0_running", 32'(bus.RUNNING[2]), 32'h0);
    chk("t0_done", 32'(bus.DONE[2]), 32'h1);
    chk("t0_pend", 32'(bus.PENDING[2]), 32'h1);

    // Start and stop together: stop wins
    step(0, 1, 0, 0, 0, 0, 4'b1000, 4'b1000, '0);
    chk("ss_running", 32'(bus.RUNNING[3]), 32'h0);
    chk("ss_done", 32'(bus.DONE[3]), 32'h0);

    // Ack colliding with a fresh expiry
    do_reset();
    step(0, 0, 1, 0, 0, 0, 4'b0001, '0, '0);
    idle(0);
    chk("race_irq0", 32'(bus.IRQ), 32'h1);
    step(0, 0, 0, 0, 0, 0, 4'b0001, '0, 4'b0001);
    chk("race_pend", 32'(bus.PENDING[0]), 32'h1);
    chk("race_irq", 32'(bus.IRQ), 32'h1);
    step(0, 0, 0, 0, 0, 0, '0, '0, 4'b0001);
    chk("ack_clear", 32'(bus.PENDING[0]), 32'h0);

    // Reset in the middle of a count
    do_reset();
    step(0, 0, 1, 0, 10, 0, 4'b0001, '0, '0);
    repeat (2 * TP) idle(1);
    step(1, 1, 1, 0, 3, 0, 4'b0001, '0, '0);
    chk("mid_running", 32'(bus.RUNNING), 32'h0);
    chk("mid_done", 32'(bus.DONE), 32'h0);
    chk("mid_pend", 32'(bus.PENDING), 32'h0);
    chk("mid_irq", 32'(bus.IRQ), 32'h0);
    step(0, 0, 1, 0, 10, 0, 4'b0001, '0, '0);
    repeat (10 * TP - 1) idle(1);
    chk("mid_early", 32'(bus.DONE[0]), 32'h0);
    idle(1);
    chk("mid_full", 32'(bus.DONE[0]), 32'h1);

    // Expiry latency in CE cycles for term 2
    do_reset();
    step(0, 0, 1, 0, 2, 0, 4'b0001, '0, '0);
    n = 0;
    while (!bus.DONE[0] && n < 50) begin
      idle(1);
      n++;
    end
    chk("ps_latency", 32'(n), 32'(2 * TP));

    // Random traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      bit [NCH-1:0] st;
      bit [NCH-1:0] sp;
      bit [NCH-1:0] ak;
      for (int i = 0; i < NCH; i++) begin
        st[i] = ($urandom_range(0, 9) == 0);
        sp[i] = ($urandom_range(0, 19) == 0);
        ak[i] = ($urandom_range(0, 3) == 0);
      end
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0,
           int'($urandom_range(0, NCH - 1)),
           int'($urandom_range(0, 6)),
           $urandom_range(0, 1) == 1,
           st, sp, ak);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
